// File: rtl/relogio_pkg.sv
// relogio_pkg: shared state type, BCD limits and time-field increment helpers for the clock.
package relogio_pkg;
  typedef enum logic [1:0] {RUN, SET_H, SET_M, LOAD} estado_ajuste_t;
  localparam int HR_MAX_MSD = 2;
  localparam int HR_MAX_LSD_AT_2 = 3;
  localparam int MIN_MAX_MSD = 5;
  localparam int BCD_MAX = 9;
  // Anything at or past 23 (including out-of-range loads) wraps to 00.
  function automatic logic [5:0] inc_horas(input logic [1:0] msd, input logic [3:0] lsd);
    logic wrap;
    wrap = msd > 2'(HR_MAX_MSD) || (msd == 2'(HR_MAX_MSD) && lsd >= 4'(HR_MAX_LSD_AT_2));
    return wrap ? 6'd0 : lsd >= 4'(BCD_MAX) ? {msd + 2'd1, 4'd0} : {msd, lsd + 4'd1};
  endfunction
  function automatic logic [6:0] inc_min(input logic [2:0] msd, input logic [3:0] lsd);
    logic wrap;
    wrap = msd > 3'(MIN_MAX_MSD) || (msd == 3'(MIN_MAX_MSD) && lsd >= 4'(BCD_MAX));
    return wrap ? 7'd0 : lsd >= 4'(BCD_MAX) ? {msd + 3'd1, 4'd0} : {msd, lsd + 4'd1};
  endfunction
endpackage

// File: rtl/debounce_botao.sv
// debounce_botao: 2-FF synchronizer, stability debouncer and one-cycle rising-edge pulse.
module debounce_botao #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulso_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1_q, s2_q, nivel_q, nivel_ant_q, pulso_q;
  logic [CW-1:0] cnt_q;
  logic difere, aceita;
  assign difere = s2_q != nivel_q;
  assign aceita = difere && cnt_q == CW'(DEB_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      nivel_q <= 1'b0;
      nivel_ant_q <= 1'b0;
      pulso_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      cnt_q <= (difere && !aceita) ? cnt_q + 1'b1 : '0;
      nivel_q <= aceita ? s2_q : nivel_q;
      nivel_ant_q <= nivel_q;
      pulso_q <= nivel_q & ~nivel_ant_q;
    end
  assign pulso_o = pulso_q;
endmodule

// File: rtl/ajuste_relogio.sv
// ajuste_relogio: button-driven HH:MM setting FSM with freeze, one-cycle load and field blink.
module ajuste_relogio
  import relogio_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int BLINK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_modo,
  input  logic       btn_inc,
  input  logic [1:0] cur_h_msd,
  input  logic [3:0] cur_h_lsd,
  input  logic [2:0] cur_m_msd,
  input  logic [3:0] cur_m_lsd,
  output logic       editando,
  output logic       load,
  output logic [1:0] set_h_msd,
  output logic [3:0] set_h_lsd,
  output logic [2:0] set_m_msd,
  output logic [3:0] set_m_lsd,
  output logic       blank_h,
  output logic       blank_m
);
  localparam int BW = $clog2(BLINK_DIV) > 0 ? $clog2(BLINK_DIV) : 1;
  estado_ajuste_t estado_q, estado_d;
  logic [1:0] h_msd_q, h_msd_d;
  logic [3:0] h_lsd_q, h_lsd_d;
  logic [2:0] m_msd_q, m_msd_d;
  logic [3:0] m_lsd_q, m_lsd_d;
  logic [BW-1:0] pisca_q, pisca_d;
  logic fase_q, fase_d;
  logic editando_q, load_q, blank_h_q, blank_m_q;
  logic modo_p, inc_p, pisca_fim, edita_d;
  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_modo (.clk, .rst, .btn_i(btn_modo), .pulso_o(modo_p));
  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_inc (.clk, .rst, .btn_i(btn_inc), .pulso_o(inc_p));
  assign pisca_fim = pisca_q == BW'(BLINK_DIV - 1);
  assign edita_d = estado_d == SET_H || estado_d == SET_M;
  always_comb begin
    estado_d = estado_q;
    {h_msd_d, h_lsd_d} = {h_msd_q, h_lsd_q};
    {m_msd_d, m_lsd_d} = {m_msd_q, m_lsd_q};
    case (estado_q)
      RUN: if (modo_p) begin
        estado_d = SET_H;
        {h_msd_d, h_lsd_d} = {cur_h_msd, cur_h_lsd};
        {m_msd_d, m_lsd_d} = {cur_m_msd, cur_m_lsd};
      end
      SET_H: if (modo_p) estado_d = SET_M;
      else if (inc_p) {h_msd_d, h_lsd_d} = inc_horas(h_msd_q, h_lsd_q);
      SET_M: if (modo_p) estado_d = LOAD;
      else if (inc_p) {m_msd_d, m_lsd_d} = inc_min(m_msd_q, m_lsd_q);
      default: estado_d = RUN;
    endcase
    // Restart the blink on any state change or edit so the field is shown right away.
    pisca_d = (estado_d != estado_q || inc_p || !edita_d || pisca_fim) ? '0 : pisca_q + 1'b1;
    fase_d = (estado_d != estado_q || inc_p || !edita_d) ? 1'b0 : fase_q ^ pisca_fim;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      estado_q <= RUN;
      {h_msd_q, h_lsd_q, m_msd_q, m_lsd_q} <= '0;
      pisca_q <= '0;
      fase_q <= 1'b0;
      editando_q <= 1'b0;
      load_q <= 1'b0;
      blank_h_q <= 1'b0;
      blank_m_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      {h_msd_q, h_lsd_q, m_msd_q, m_lsd_q} <= {h_msd_d, h_lsd_d, m_msd_d, m_lsd_d};
      pisca_q <= pisca_d;
      fase_q <= fase_d;
      editando_q <= edita_d;
      load_q <= estado_d == LOAD;
      blank_h_q <= estado_d == SET_H && fase_d;
      blank_m_q <= estado_d == SET_M && fase_d;
    end
  assign editando = editando_q;
  assign load = load_q;
  assign {set_h_msd, set_h_lsd, set_m_msd, set_m_lsd} = {h_msd_q, h_lsd_q, m_msd_q, m_lsd_q};
  assign blank_h = blank_h_q;
  assign blank_m = blank_m_q;
endmodule

// File: tb/tb_ajuste_relogio.sv
// tb_ajuste_relogio: directed and randomized button sequences checked against an integer time model.
module tb_ajuste_relogio;
  logic clk = 1'b0, rst = 1'b1, btn_modo = 1'b0, btn_inc = 1'b0;
  logic [1:0] cur_h_msd = '0;
  logic [3:0] cur_h_lsd = '0;
  logic [2:0] cur_m_msd = '0;
  logic [3:0] cur_m_lsd = '0;
  logic editando, load, blank_h, blank_m;
  logic [1:0] set_h_msd;
  logic [3:0] set_h_lsd;
  logic [2:0] set_m_msd;
  logic [3:0] set_m_lsd;
  int passed = 0, total = 0;
  int st = 0, h_ref = 0, m_ref = 0, cur_h = 0, cur_m = 0;
  int load_cnt = 0, ld_h = 0, ld_m = 0;
  always #5 clk = ~clk;
  ajuste_relogio #(.DEB_CYCLES(16), .BLINK_DIV(8)) dut (
    .clk(clk), .rst(rst), .btn_modo(btn_modo), .btn_inc(btn_inc),
    .cur_h_msd(cur_h_msd), .cur_h_lsd(cur_h_lsd), .cur_m_msd(cur_m_msd), .cur_m_lsd(cur_m_lsd),
    .editando(editando), .load(load),
    .set_h_msd(set_h_msd), .set_h_lsd(set_h_lsd), .set_m_msd(set_m_msd), .set_m_lsd(set_m_lsd),
    .blank_h(blank_h), .blank_m(blank_m));
  function automatic int sh();
    return int'(set_h_msd) * 10 + int'(set_h_lsd);
  endfunction
  function automatic int sm();
    return int'(set_m_msd) * 10 + int'(set_m_lsd);
  endfunction
  always @(negedge clk)
    if (load === 1'b1) begin
      load_cnt++;
      ld_h = sh();
      ld_m = sm();
    end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic set_cur(input int h, input int m);
    cur_h = h;
    cur_m = m;
    cur_h_msd = 2'(h / 10);
    cur_h_lsd = 4'(h % 10);
    cur_m_msd = 3'(m / 10);
    cur_m_lsd = 4'(m % 10);
  endtask
  task automatic check_fields(input string tag);
    check({tag, "_editando"}, int'(editando), int'(st == 1 || st == 2));
    check({tag, "_set_h"}, sh(), h_ref);
    check({tag, "_set_m"}, sm(), m_ref);
  endtask
  task automatic do_modo();
    int lc;
    lc = load_cnt;
    btn_modo = 1'b1;
    tick(25);
    btn_modo = 1'b0;
    tick(25);
    if (st == 0) begin
      st = 1;
      h_ref = cur_h;
      m_ref = cur_m;
    end else if (st == 1) st = 2;
    else st = 0;
    if (st == 0) begin
      check("load_pulses", load_cnt - lc, 1);
      check("load_h", ld_h, h_ref);
      check("load_m", ld_m, m_ref);
    end else check("no_load", load_cnt - lc, 0);
    check_fields("modo");
  endtask
  task automatic inc_model();
    if (st == 1) h_ref = (h_ref >= 23) ? 0 : h_ref + 1;
    if (st == 2) m_ref = (m_ref >= 59) ? 0 : m_ref + 1;
  endtask
  task automatic do_inc();
    btn_inc = 1'b1;
    tick(25);
    btn_inc = 1'b0;
    tick(25);
    inc_model();
    check_fields("inc");
  endtask
  task automatic blink_test();
    logic prev;
    int n;
    prev = blank_m;
    n = 0;
    while (blank_m === prev && n < 30) begin
      tick(1);
      n++;
    end
    check("blink_started", int'(n < 30), 1);
    for (int k = 0; k < 3; k++) begin
      prev = blank_m;
      n = 0;
      do begin
        tick(1);
        n++;
      end while (blank_m === prev && n < 30);
      check("blink_period", n, 8);
      check("blink_h_off", int'(blank_h), 0);
    end
    btn_inc = 1'b1;
    n = 0;
    while (sm() == m_ref && n < 40) begin
      tick(1);
      n++;
    end
    check("inc_seen", int'(n < 40), 1);
    check("blank_after_inc", int'(blank_m), 0);
    tick(25 - (n % 25));
    btn_inc = 1'b0;
    tick(25);
    inc_model();
    check_fields("blink_inc");
  endtask
  initial begin
    int lc;
    tick(2);
    check("rst_editando", int'(editando), 0);
    check("rst_load", int'(load), 0);
    check("rst_set", int'({set_h_msd, set_h_lsd, set_m_msd, set_m_lsd}), 0);
    check("rst_blank", int'({blank_h, blank_m}), 0);
    rst = 1'b0;
    tick(3);
    set_cur(12, 34);
    do_modo();
    repeat (3) do_inc();
    do_modo();
    repeat (2) do_inc();
    do_modo();
    set_cur(22, 58);
    do_modo();
    repeat (2) do_inc();
    do_modo();
    repeat (2) do_inc();
    do_modo();
    set_cur(5, 7);
    do_modo();
    repeat (5) begin
      btn_inc = 1'b1;
      tick(15);
      btn_inc = 1'b0;
      tick(15);
    end
    tick(10);
    check_fields("bounce");
    btn_inc = 1'b1;
    tick(200);
    btn_inc = 1'b0;
    tick(25);
    inc_model();
    check_fields("held");
    btn_modo = 1'b1;
    btn_inc = 1'b1;
    tick(25);
    btn_modo = 1'b0;
    btn_inc = 1'b0;
    tick(25);
    st = 2;
    check_fields("coincide");
    do_inc();
    blink_test();
    do_modo();
    for (int r = 0; r < 5; r++) begin
      set_cur(int'($urandom_range(29, 0)), int'($urandom_range(59, 0)));
      do_modo();
      repeat ($urandom_range(4, 0)) do_inc();
      do_modo();
      repeat ($urandom_range(4, 0)) do_inc();
      do_modo();
    end
    set_cur(9, 41);
    do_modo();
    do_inc();
    do_modo();
    do_inc();
    lc = load_cnt;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    st = 0;
    h_ref = 0;
    m_ref = 0;
    check_fields("midrst");
    check("midrst_load", int'(load), 0);
    tick(3);
    rst = 1'b0;
    tick(10);
    check("midrst_no_load", load_cnt - lc, 0);
    check_fields("after_rst");
    set_cur(3, 15);
    do_modo();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
